// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and FSM encoding for the LCD number formatter
package lcd_pkg;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam int         MSG_LEN       = 16;
  typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;
endpackage

// File: rtl/bcd_conv_seq.sv
// bcd_conv_seq: sequential double-dabble, 10-bit binary to 4 BCD digits in 10 shifts
module bcd_conv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        done,
  output logic [15:0] bcd
);
  logic [15:0] bcd_q, bcd_d;
  logic [11:0] adj;
  logic [9:0]  sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;
  // 1023 keeps the thousands digit below 5, so only the lower three digits need the add-3 fixup
  for (genvar d = 0; d < 3; d++) begin : g_adj
    assign adj[4*d+:4] = bcd_q[4*d+:4] >= 4'd5 ? bcd_q[4*d+:4] + 4'd3 : bcd_q[4*d+:4];
  end
  always_comb begin
    bcd_d  = start ? '0 : busy_q ? {bcd_q[14:12], adj, sh_q[9]} : bcd_q;
    sh_d   = start ? bin : busy_q ? {sh_q[8:0], 1'b0} : sh_q;
    cnt_d  = start ? '0 : busy_q ? cnt_q + 4'd1 : cnt_q;
    busy_d = start || (busy_q && cnt_q != 4'd9);
    done_d = busy_q && cnt_q == 4'd9;
  end
  always_ff @(negedge clk) begin
    if (rst) begin
      bcd_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule

// File: rtl/lcd_num_formatter.sv
// lcd_num_formatter: formats a 10-bit value as a two-line LCD message (decimal, then binary)
module lcd_num_formatter
  import lcd_pkg::*;
#(
  parameter logic LEAD_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inValid,
  input  logic [9:0] value,
  output logic       inReady,
  output logic       outValid,
  output logic [7:0] outData,
  output logic       outRS,
  input  logic       outReady
);
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d, dig, bi;
  logic [9:0]  val_q, val_d;
  logic [15:0] bcd;
  logic [7:0]  chr;
  logic        conv_done, b3, b2, b1, blank;
  bcd_conv_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (inReady && inValid),
    .bin   (value),
    .done  (conv_done),
    .bcd   (bcd)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    case (state_q)
      IDLE:    if (inValid) begin
        state_d = CONVERT;
        val_d   = value;
      end
      CONVERT: if (conv_done) begin
        state_d = EMIT;
        idx_d   = '0;
      end
      EMIT:    if (outReady) begin
        if (idx_q == 4'(MSG_LEN - 1)) state_d = IDLE;
        else idx_d = idx_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
    end
  end
  // a digit blanks only while every more-significant digit is also zero
  always_comb begin
    b3    = LEAD_BLANK && bcd[15:12] == 4'd0;
    b2    = b3 && bcd[11:8] == 4'd0;
    b1    = b2 && bcd[7:4] == 4'd0;
    dig   = idx_q == 4'd1 ? bcd[15:12] : idx_q == 4'd2 ? bcd[11:8] : idx_q == 4'd3 ? bcd[7:4] : bcd[3:0];
    blank = idx_q == 4'd1 ? b3 : idx_q == 4'd2 ? b2 : idx_q == 4'd3 ? b1 : 1'b0;
    bi    = 4'd15 - idx_q;
    chr   = idx_q == 4'd0 ? LCD_CMD_LINE1 :
            idx_q == 4'd5 ? LCD_CMD_LINE2 :
            idx_q <  4'd5 ? (blank ? ASCII_SPACE : ASCII_ZERO | {4'h0, dig}) :
                            ASCII_ZERO | {7'h0, val_q[bi]};
  end
  assign inReady  = state_q == IDLE;
  assign outValid = state_q == EMIT;
  assign outData  = outValid ? chr : 8'h00;
  assign outRS    = outValid && idx_q != 4'd0 && idx_q != 4'd5;
endmodule

// File: tb/tb_lcd_num_formatter.sv
// tb_lcd_num_formatter: scoreboard bench driving a blanking and a non-blanking formatter in lockstep
module tb_lcd_num_formatter;
  logic       clk = 1'b0, rst = 1'b1, inValid = 1'b0, outReady = 1'b1;
  logic [9:0] value = '0;
  logic       inReady1, outValid1, outRS1, inReady0, outValid0, outRS0;
  logic [7:0] outData1, outData0;
  logic [8:0] q1[$], q0[$];
  int         checks = 0, errors = 0, pops = 0;

  always #5 clk = ~clk;

  lcd_num_formatter #(.LEAD_BLANK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .inValid(inValid), .value(value), .inReady(inReady1),
    .outValid(outValid1), .outData(outData1), .outRS(outRS1), .outReady(outReady));
  lcd_num_formatter #(.LEAD_BLANK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .inValid(inValid), .value(value), .inReady(inReady0),
    .outValid(outValid0), .outData(outData0), .outRS(outRS0), .outReady(outReady));

  function automatic logic [8:0] exp_byte(int v, int i, bit lb);
    int d[4];
    bit bl;
    d[0] = v / 1000; d[1] = v / 100 % 10; d[2] = v / 10 % 10; d[3] = v % 10;
    if (i == 0) return {1'b0, 8'h80};
    if (i == 5) return {1'b0, 8'hC0};
    if (i > 5) return {1'b1, 8'h30 + 8'((v >> (15 - i)) & 1)};
    bl = lb && i < 4;
    for (int k = 0; k < i; k++) if (d[k] != 0) bl = 1'b0;
    return bl ? 9'h120 : {1'b1, 8'h30 + 8'(d[i-1])};
  endfunction

  task automatic push_msg(int v);
    for (int i = 0; i < 16; i++) begin
      q1.push_back(exp_byte(v, i, 1'b1));
      q0.push_back(exp_byte(v, i, 1'b0));
    end
  endtask

  // DUT updates on negedge; sample at posedge, drive just after negedge
  always @(posedge clk) if (!rst) begin
    if (outValid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++; $display("FAIL byte_lb1 got %h expected none", {outRS1, outData1});
      end else if ({outRS1, outData1} !== q1[0]) begin
        errors++; $display("FAIL byte_lb1 got %h expected %h", {outRS1, outData1}, q1[0]);
      end
      if (outReady && q1.size() > 0) begin void'(q1.pop_front()); pops++; end
    end
    if (outValid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++; $display("FAIL byte_lb0 got %h expected none", {outRS0, outData0});
      end else if ({outRS0, outData0} !== q0[0]) begin
        errors++; $display("FAIL byte_lb0 got %h expected %h", {outRS0, outData0}, q0[0]);
      end
      if (outReady && q0.size() > 0) void'(q0.pop_front());
    end
  end

  task automatic send(int v);
    int n = 0;
    while (!inReady1 && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (!inReady1) begin errors++; $display("FAIL send_ready got 0 expected 1"); end
    inValid = 1'b1; value = 10'(v);
    push_msg(v);
    @(negedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic drain(int mode, int bound);
    int n = 0;
    while ((q1.size() > 0 || q0.size() > 0) && n < bound) begin
      outReady = mode == 0 ? 1'b1 : mode == 1 ? ~outReady : 1'($urandom_range(0, 1));
      @(negedge clk); #1; n++;
    end
    outReady = 1'b1;
    checks++;
    if (q1.size() > 0 || q0.size() > 0) begin
      errors++; $display("FAIL drain_timeout got %0d left expected 0", q1.size());
      q1.delete(); q0.delete();
    end
    checks++;
    if ({outValid1, inReady1, outValid0, inReady0} !== 4'b0101)
      begin errors++; $display("FAIL end_idle got %b expected 0101", {outValid1, inReady1, outValid0, inReady0}); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({inReady1, outValid1, outRS1, outData1, inReady0, outValid0, outRS0, outData0} !== {3'b100, 8'h00, 3'b100, 8'h00})
      begin errors++; $display("FAIL reset_state got %b %h %b %h expected 100 00", {inReady1, outValid1, outRS1}, outData1, {inReady0, outValid0, outRS0}, outData0); end
    rst = 1'b0;
  endtask

  task automatic test_max_latency();
    outReady = 1'b1;
    send(1023);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++;
      if (outValid1 !== (k == 11)) begin errors++; $display("FAIL latency_N+%0d got %b expected %b", k, outValid1, k == 11); end
    end
    drain(0, 100);
  endtask

  task automatic test_blank();
    send(5);
    drain(0, 100);
    send(0);
    drain(0, 100);
    send(100);
    drain(0, 100);
  endtask

  task automatic test_stall();
    send(682);
    drain(1, 100);
    send(9);
    drain(2, 200);
    send(999);
    drain(2, 200);
  endtask

  task automatic test_ignore_busy();
    send(682);
    inValid = 1'b1; value = 10'd100;
    drain(0, 100);
    push_msg(100);
    @(negedge clk); #1;
    inValid = 1'b0; value = 10'd0;
    checks++;
    if ({inReady1, outValid1} !== 2'b00) begin errors++; $display("FAIL capture_after_idle got %b expected 00", {inReady1, outValid1}); end
    drain(0, 100);
  endtask

  task automatic test_back_to_back();
    int vals[6] = '{10, 1000, 1, 99, 512, 1023};
    foreach (vals[i]) begin
      send(vals[i]);
      drain(i % 3, 200);
    end
  endtask

  task automatic test_reset_mid();
    int base, n = 0;
    send(682);
    base = pops;
    while (pops < base + 8 && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (pops < base + 8) begin errors++; $display("FAIL mid_bytes got %0d expected 8", pops - base); end
    outReady = 1'b0; rst = 1'b1;
    q1.delete(); q0.delete();
    @(negedge clk); #1;
    rst = 1'b0; outReady = 1'b1;
    checks++;
    if ({inReady1, outValid1, outRS1, outData1, inReady0, outValid0} !== {3'b100, 8'h00, 2'b10})
      begin errors++; $display("FAIL mid_reset got %b %h expected 100 00", {inReady1, outValid1, outRS1}, outData1); end
    repeat (14) @(negedge clk);
    #1;
    checks++;
    if ({outValid1, outValid0} !== 2'b00) begin errors++; $display("FAIL abandoned got %b expected 00", {outValid1, outValid0}); end
    send(1);
    drain(0, 100);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_max_latency();
    test_blank();
    test_stall();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
